// File: rtl/riscv_decode_execute.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : riscv_decode_execute                                   |
// | Description : RV64I single-cycle decode/execute slice: instruction   |
// |               decode, 32x64 register file, operand select, ALU,      |
// |               branch condition and writeback mux.                    |
// | Config      : define RV64W_OPS_EN to add OP-IMM-32 / OP-32 word ops. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module riscv_decode_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [63:0] mem_rdata,
    output logic [63:0] alu_result,
    output logic [63:0] rs2_data,
    output logic [3:0]  alu_opr,
    output logic [2:0]  load_flag,
    output logic [1:0]  store_flag,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic        branch_en,
    output logic        reg_write_en,
    output logic        branch_mux
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
`ifdef RV64W_OPS_EN
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
`endif

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    typedef enum logic [1:0] {
        OP2_ZERO  = 2'd0,
        OP2_RS2   = 2'd1,
        OP2_IMM_I = 2'd2,
        OP2_IMM_S = 2'd3
    } op2_sel_e;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [4:0]  w_rd_idx;
    logic [63:0] w_imm_i;
    logic [63:0] w_imm_s;
    logic [63:0] w_rs1_data;
    logic [63:0] w_op2;
    logic [63:0] w_alu;
    logic [63:0] w_wb_data;
    logic        w_cond;
    op2_sel_e    w_op2_sel;
`ifdef RV64W_OPS_EN
    logic        w_word;
    logic        w_hit;
    logic [31:0] w_res32;
`endif

    logic [63:0] regs_q [32];
    logic [63:0] regs_d [32];

    assign w_opcode  = instr[6:0];
    assign w_funct3  = instr[14:12];
    assign w_rs1_idx = instr[19:15];
    assign w_rs2_idx = instr[24:20];
    assign w_rd_idx  = instr[11:7];
    assign w_imm_i   = {{52{instr[31]}}, instr[31:20]};
    assign w_imm_s   = {{52{instr[31]}}, instr[31:25], instr[11:7]};

    // x0 is hardwired to zero regardless of what the array holds
    assign w_rs1_data = (w_rs1_idx == 5'd0) ? 64'd0 : regs_q[w_rs1_idx];
    assign rs2_data   = (w_rs2_idx == 5'd0) ? 64'd0 : regs_q[w_rs2_idx];

    // Instruction decode: unlisted encodings fall back to the all-off defaults
    always_comb begin
        alu_opr      = ALU_ADD;
        w_op2_sel    = OP2_ZERO;
        load_flag    = 3'b000;
        store_flag   = 2'b00;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        branch_en    = 1'b0;
        reg_write_en = 1'b0;
`ifdef RV64W_OPS_EN
        w_word = 1'b0;
        w_hit  = 1'b0;
`endif
        case (w_opcode)
            OPC_OP, OPC_OP_IMM: begin
                w_op2_sel    = (w_opcode == OPC_OP) ? OP2_RS2 : OP2_IMM_I;
                reg_write_en = 1'b1;
                case (w_funct3)
                    3'b000: alu_opr = (w_opcode == OPC_OP && instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_opr = ALU_SLL;
                    3'b010: alu_opr = ALU_SLT;
                    3'b011: alu_opr = ALU_SLTU;
                    3'b100: alu_opr = ALU_XOR;
                    3'b101: alu_opr = instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_opr = ALU_OR;
                    3'b111: alu_opr = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                if (w_funct3 != 3'b111) begin
                    w_op2_sel    = OP2_IMM_I;
                    mem_read_en  = 1'b1;
                    reg_write_en = 1'b1;
                    load_flag    = w_funct3;
                end
            end
            OPC_STORE: begin
                if (!w_funct3[2]) begin
                    w_op2_sel    = OP2_IMM_S;
                    mem_write_en = 1'b1;
                    store_flag   = w_funct3[1:0];
                end
            end
            OPC_BRANCH: begin
                if (w_funct3[2:1] != 2'b01) begin
                    w_op2_sel = OP2_RS2;
                    branch_en = 1'b1;
                    alu_opr   = w_funct3[2] ? {2'b11, w_funct3[1:0]} : {3'b101, w_funct3[0]};
                end
            end
`ifdef RV64W_OPS_EN
            OPC_OP_IMM_32, OPC_OP_32: begin
                w_hit = 1'b1;
                case (w_funct3)
                    3'b000:  alu_opr = (w_opcode == OPC_OP_32 && instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_opr = ALU_SLL;
                    3'b101:  alu_opr = instr[30] ? ALU_SRA : ALU_SRL;
                    default: w_hit = 1'b0;
                endcase
                if (w_hit) begin
                    w_op2_sel    = (w_opcode == OPC_OP_32) ? OP2_RS2 : OP2_IMM_I;
                    reg_write_en = 1'b1;
                    w_word       = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Second ALU operand select
    always_comb begin
        case (w_op2_sel)
            OP2_RS2:   w_op2 = rs2_data;
            OP2_IMM_I: w_op2 = w_imm_i;
            OP2_IMM_S: w_op2 = w_imm_s;
            default:   w_op2 = 64'd0;
        endcase
    end

    // ALU: branch codes fall into the default arm and yield rs1 - rs2
    always_comb begin
        w_alu = w_rs1_data + w_op2;
        case (alu_opr)
            ALU_AND:  w_alu = w_rs1_data & w_op2;
            ALU_OR:   w_alu = w_rs1_data | w_op2;
            ALU_ADD:  w_alu = w_rs1_data + w_op2;
            ALU_XOR:  w_alu = w_rs1_data ^ w_op2;
            ALU_SLL:  w_alu = w_rs1_data << w_op2[5:0];
            ALU_SRL:  w_alu = w_rs1_data >> w_op2[5:0];
            ALU_SRA:  w_alu = $signed(w_rs1_data) >>> w_op2[5:0];
            ALU_SLT:  w_alu = {63'd0, $signed(w_rs1_data) < $signed(w_op2)};
            ALU_SLTU: w_alu = {63'd0, w_rs1_data < w_op2};
            default:  w_alu = w_rs1_data - w_op2;
        endcase
`ifdef RV64W_OPS_EN
        // Word ops work on the low half with 5-bit shifts, then sign-extend
        case (alu_opr)
            ALU_SUB: w_res32 = w_rs1_data[31:0] - w_op2[31:0];
            ALU_SLL: w_res32 = w_rs1_data[31:0] << w_op2[4:0];
            ALU_SRL: w_res32 = w_rs1_data[31:0] >> w_op2[4:0];
            ALU_SRA: w_res32 = $signed(w_rs1_data[31:0]) >>> w_op2[4:0];
            default: w_res32 = w_rs1_data[31:0] + w_op2[31:0];
        endcase
        if (w_word) begin
            w_alu = {{32{w_res32[31]}}, w_res32};
        end
`endif
    end

    assign alu_result = w_alu;

    // Branch condition evaluated on the full 64-bit operands
    always_comb begin
        w_cond = 1'b0;
        case (alu_opr)
            ALU_BEQ:  w_cond = (w_rs1_data == w_op2);
            ALU_BNE:  w_cond = (w_rs1_data != w_op2);
            ALU_BLT:  w_cond = ($signed(w_rs1_data) <  $signed(w_op2));
            ALU_BGE:  w_cond = ($signed(w_rs1_data) >= $signed(w_op2));
            ALU_BLTU: w_cond = (w_rs1_data <  w_op2);
            ALU_BGEU: w_cond = (w_rs1_data >= w_op2);
            default:  w_cond = 1'b0;
        endcase
    end

    assign branch_mux = ~(branch_en & w_cond);
    assign w_wb_data  = mem_read_en ? mem_rdata : w_alu;

    // Next register-file contents: single write port, x0 never written
    always_comb begin
        regs_d = regs_q;
        if (reg_write_en && (w_rd_idx != 5'd0)) begin
            regs_d[w_rd_idx] = w_wb_data;
        end
    end

    // Register-file state; reset wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_execute.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_riscv_decode_execute                                |
// | Description : Self-checking bench: directed program followed by     |
// |               randomized instructions against a mnemonic-level model.|
// | Config      : honours RV64W_OPS_EN for the word-op kinds.            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_riscv_decode_execute;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
`ifdef RV64W_OPS_EN
    localparam int NK = 33;
`else
    localparam int NK = 25;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [63:0] mem_rdata;
    logic [63:0] alu_result, rs2_data;
    logic [3:0]  alu_opr;
    logic [2:0]  load_flag;
    logic [1:0]  store_flag;
    logic        mem_write_en, mem_read_en, branch_en, reg_write_en, branch_mux;

    int checks = 0;
    int errors = 0;
    logic [63:0] mreg [32];

    riscv_decode_execute dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_rdata(mem_rdata),
        .alu_result(alu_result), .rs2_data(rs2_data), .alu_opr(alu_opr),
        .load_flag(load_flag), .store_flag(store_flag),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .branch_en(branch_en), .reg_write_en(reg_write_en), .branch_mux(branch_mux)
    );

    always #5 clk = ~clk;

    // {mem_write_en, mem_read_en, branch_en, reg_write_en, branch_mux, load_flag, store_flag}
    wire [9:0] ctrl = {mem_write_en, mem_read_en, branch_en, reg_write_en, branch_mux, load_flag, store_flag};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ctl(input bit mw, mr, be, we, mux, input logic [2:0] lf, input logic [1:0] sf);
        return {mw, mr, be, we, mux, lf, sf};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs2, rs1, input logic [2:0] f3);
        return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
    endfunction

    // Drive one instruction mid-cycle and let outputs settle before checking
    task automatic apply(input logic [31:0] ins, input logic [63:0] mrd, input logic r);
        @(negedge clk);
        instr     = ins;
        mem_rdata = mrd;
        rst       = r;
        #1;
    endtask

    // Reference: expected behaviour of one instruction chosen by mnemonic kind
    task automatic model_step(input int k, input logic [4:0] rs1, rs2, rd, input logic [11:0] imm,
                              input logic [2:0] f3r, input logic [63:0] mrd, input bit rst_now);
        logic [63:0] a, b, si, e_alu;
        logic [31:0] ins, r32;
        logic [3:0]  e_op;
        logic [2:0]  f3;
        logic [1:0]  sf;
        bit mw, mr, be, we, mux, cond, word;
        a = mreg[rs1]; b = mreg[rs2]; si = {{52{imm[11]}}, imm};
        mw = 0; mr = 0; be = 0; we = 0; mux = 1; word = 0; sf = 2'b00; f3 = 3'b000;
        e_op = 4'd2; e_alu = a; r32 = 32'd0; ins = 32'd0; cond = 0;
        case (k)
            0:  begin ins = enc_r(7'h00, rs2, rs1, 3'd0, rd, OP); e_alu = a + b; e_op = 2; we = 1; end
            1:  begin ins = enc_r(7'h20, rs2, rs1, 3'd0, rd, OP); e_alu = a - b; e_op = 6; we = 1; end
            2:  begin ins = enc_r(7'h00, rs2, rs1, 3'd1, rd, OP); e_alu = a << b[5:0]; e_op = 4; we = 1; end
            3:  begin ins = enc_r(7'h00, rs2, rs1, 3'd2, rd, OP); e_alu = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0; e_op = 8; we = 1; end
            4:  begin ins = enc_r(7'h00, rs2, rs1, 3'd3, rd, OP); e_alu = (a < b) ? 64'd1 : 64'd0; e_op = 9; we = 1; end
            5:  begin ins = enc_r(7'h00, rs2, rs1, 3'd4, rd, OP); e_alu = a ^ b; e_op = 3; we = 1; end
            6:  begin ins = enc_r(7'h00, rs2, rs1, 3'd5, rd, OP); e_alu = a >> b[5:0]; e_op = 5; we = 1; end
            7:  begin ins = enc_r(7'h20, rs2, rs1, 3'd5, rd, OP); e_alu = $signed(a) >>> b[5:0]; e_op = 7; we = 1; end
            8:  begin ins = enc_r(7'h00, rs2, rs1, 3'd6, rd, OP); e_alu = a | b; e_op = 1; we = 1; end
            9:  begin ins = enc_r(7'h00, rs2, rs1, 3'd7, rd, OP); e_alu = a & b; e_op = 0; we = 1; end
            10: begin ins = enc_i(imm, rs1, 3'd0, rd, OPI); e_alu = a + si; e_op = 2; we = 1; end
            11: begin ins = enc_i(imm, rs1, 3'd2, rd, OPI); e_alu = ($signed(a) < $signed(si)) ? 64'd1 : 64'd0; e_op = 8; we = 1; end
            12: begin ins = enc_i(imm, rs1, 3'd3, rd, OPI); e_alu = (a < si) ? 64'd1 : 64'd0; e_op = 9; we = 1; end
            13: begin ins = enc_i(imm, rs1, 3'd4, rd, OPI); e_alu = a ^ si; e_op = 3; we = 1; end
            14: begin ins = enc_i(imm, rs1, 3'd6, rd, OPI); e_alu = a | si; e_op = 1; we = 1; end
            15: begin ins = enc_i(imm, rs1, 3'd7, rd, OPI); e_alu = a & si; e_op = 0; we = 1; end
            16: begin ins = enc_i({6'b000000, imm[5:0]}, rs1, 3'd1, rd, OPI); e_alu = a << imm[5:0]; e_op = 4; we = 1; end
            17: begin ins = enc_i({6'b000000, imm[5:0]}, rs1, 3'd5, rd, OPI); e_alu = a >> imm[5:0]; e_op = 5; we = 1; end
            18: begin ins = enc_i({6'b010000, imm[5:0]}, rs1, 3'd5, rd, OPI); e_alu = $signed(a) >>> imm[5:0]; e_op = 7; we = 1; end
            19: begin
                f3 = (f3r == 3'd7) ? 3'd3 : f3r;
                ins = enc_i(imm, rs1, f3, rd, LD); e_alu = a + si; mr = 1; we = 1;
            end
            20: begin
                sf = f3r[1:0];
                ins = enc_s(imm, rs2, rs1, {1'b0, sf}); e_alu = a + si; mw = 1;
            end
            21: begin
                f3 = f3r;
                if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 + 3'd4;
                ins = enc_b(rs2, rs1, f3); e_alu = a - b; be = 1;
                e_op = (f3 < 3'd4) ? 4'(10 + f3) : 4'(8 + f3);
                case (f3)
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd4: cond = ($signed(a) <  $signed(b));
                    3'd5: cond = ($signed(a) >= $signed(b));
                    3'd6: cond = (a <  b);
                    default: cond = (a >= b);
                endcase
                mux = !cond;
            end
            22: begin
                case (f3r[1:0])
                    2'd0:    ins = {imm, rs1, f3r, rd, 7'b1111111};
                    2'd1:    ins = {imm, rs1, f3r, rd, 7'b0110111};
                    2'd2:    ins = {imm, rs1, f3r, rd, 7'b1101111};
                    default: ins = {imm, rs1, f3r, rd, 7'b0000000};
                endcase
            end
            23: begin
                case (f3r % 3)
                    0:       ins = enc_i(imm, rs1, 3'd7, rd, LD);
                    1:       ins = enc_s(imm, rs2, rs1, {1'b1, f3r[1:0]});
                    default: ins = enc_b(rs2, rs1, {2'b01, f3r[0]});
                endcase
            end
`ifdef RV64W_OPS_EN
            24: begin ins = enc_r(7'h00, rs2, rs1, 3'd0, rd, 7'h3B); r32 = a[31:0] + b[31:0]; e_op = 2; word = 1; end
            25: begin ins = enc_r(7'h20, rs2, rs1, 3'd0, rd, 7'h3B); r32 = a[31:0] - b[31:0]; e_op = 6; word = 1; end
            26: begin ins = enc_r(7'h00, rs2, rs1, 3'd1, rd, 7'h3B); r32 = a[31:0] << b[4:0]; e_op = 4; word = 1; end
            27: begin ins = enc_r(7'h00, rs2, rs1, 3'd5, rd, 7'h3B); r32 = a[31:0] >> b[4:0]; e_op = 5; word = 1; end
            28: begin ins = enc_r(7'h20, rs2, rs1, 3'd5, rd, 7'h3B); r32 = $signed(a[31:0]) >>> b[4:0]; e_op = 7; word = 1; end
            29: begin ins = enc_i(imm, rs1, 3'd0, rd, 7'h1B); r32 = a[31:0] + si[31:0]; e_op = 2; word = 1; end
            30: begin ins = enc_i({7'h00, imm[4:0]}, rs1, 3'd1, rd, 7'h1B); r32 = a[31:0] << imm[4:0]; e_op = 4; word = 1; end
            31: begin ins = enc_i({7'h00, imm[4:0]}, rs1, 3'd5, rd, 7'h1B); r32 = a[31:0] >> imm[4:0]; e_op = 5; word = 1; end
            default: begin ins = enc_i({7'h20, imm[4:0]}, rs1, 3'd5, rd, 7'h1B); r32 = $signed(a[31:0]) >>> imm[4:0]; e_op = 7; word = 1; end
`else
            default: ins = {imm, rs1, f3r, rd, f3r[0] ? 7'h3B : 7'h1B};
`endif
        endcase
        if (word) begin
            e_alu = {{32{r32[31]}}, r32};
            we = 1;
        end
        apply(ins, mrd, rst_now);
        chk($sformatf("k%0d alu", k), alu_result, e_alu);
        chk($sformatf("k%0d rs2", k), rs2_data, mreg[ins[24:20]]);
        chk($sformatf("k%0d opr", k), 64'(alu_opr), 64'(e_op));
        chk($sformatf("k%0d ctrl", k), 64'(ctrl), 64'(ctl(mw, mr, be, we, mux, mr ? f3 : 3'd0, sf)));
        if (rst_now) begin
            foreach (mreg[i]) mreg[i] = 64'd0;
        end else if (we && ins[11:7] != 5'd0) begin
            mreg[ins[11:7]] = mr ? mrd : e_alu;
        end
    endtask

    initial begin
        foreach (mreg[i]) mreg[i] = 64'd0;
        rst = 1'b1; instr = 32'd0; mem_rdata = 64'd0;
        repeat (2) @(posedge clk);

        // Directed program
        apply(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 64'd0, 1'b0);
        chk("reset_alu", alu_result, 64'd0);
        chk("reset_rs2", rs2_data, 64'd0);
        chk("add_ctrl", 64'(ctrl), 64'(ctl(0, 0, 0, 1, 1, 3'd0, 2'd0)));
        apply(enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, OPI), 64'd0, 1'b0);
        chk("addi_neg5", alu_result, 64'hFFFF_FFFF_FFFF_FFFB);
        apply(enc_i(12'h401, 5'd1, 3'd5, 5'd2, OPI), 64'd0, 1'b0);
        chk("srai", alu_result, 64'hFFFF_FFFF_FFFF_FFFD);
        apply(enc_i(12'd7, 5'd0, 3'd0, 5'd0, OPI), 64'd0, 1'b0);
        chk("addi_x0", alu_result, 64'd7);
        apply(enc_r(7'h00, 5'd0, 5'd2, 3'd0, 5'd3, OP), 64'd0, 1'b0);
        chk("x0_reads_0", rs2_data, 64'd0);
        chk("x2_written", alu_result, 64'hFFFF_FFFF_FFFF_FFFD);
        apply(enc_i(12'd3, 5'd0, 3'd0, 5'd4, OPI), 64'd0, 1'b0);
        apply(enc_r(7'h00, 5'd4, 5'd1, 3'd2, 5'd5, OP), 64'd0, 1'b0);
        chk("slt", alu_result, 64'd1);
        apply(enc_r(7'h00, 5'd4, 5'd1, 3'd3, 5'd5, OP), 64'd0, 1'b0);
        chk("sltu", alu_result, 64'd0);
        apply(enc_r(7'h20, 5'd1, 5'd4, 3'd0, 5'd6, OP), 64'd0, 1'b0);
        chk("sub", alu_result, 64'd8);
        apply(enc_i(12'd16, 5'd4, 3'd3, 5'd7, LD), 64'h1234, 1'b0);
        chk("ld_addr", alu_result, 64'd19);
        chk("ld_ctrl", 64'(ctrl), 64'(ctl(0, 1, 0, 1, 1, 3'd3, 2'd0)));
        apply(enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd8, OP), 64'd0, 1'b0);
        chk("ld_wb", alu_result, 64'h1234);
        apply(enc_s(12'hFFC, 5'd4, 5'd4, 3'd2), 64'd0, 1'b0);
        chk("sw_addr", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sw_data", rs2_data, 64'd3);
        chk("sw_ctrl", 64'(ctrl), 64'(ctl(1, 0, 0, 0, 1, 3'd0, 2'd2)));
        apply(enc_b(5'd4, 5'd4, 3'd0), 64'd0, 1'b0);
        chk("beq_ctrl", 64'(ctrl), 64'(ctl(0, 0, 1, 0, 0, 3'd0, 2'd0)));
        apply(enc_b(5'd4, 5'd4, 3'd1), 64'd0, 1'b0);
        chk("bne_ctrl", 64'(ctrl), 64'(ctl(0, 0, 1, 0, 1, 3'd0, 2'd0)));
        apply(enc_b(5'd4, 5'd1, 3'd7), 64'd0, 1'b0);
        chk("bgeu_ctrl", 64'(ctrl), 64'(ctl(0, 0, 1, 0, 0, 3'd0, 2'd0)));
        apply(32'hFFF0_FFFF, 64'd0, 1'b0);
        chk("unk_ctrl", 64'(ctrl), 64'(ctl(0, 0, 0, 0, 1, 3'd0, 2'd0)));
        chk("unk_opr", 64'(alu_opr), 64'd2);
        chk("unk_alu", alu_result, 64'hFFFF_FFFF_FFFF_FFFB);

        // Mid-program reset: the pending write is dropped and x1 clears
        apply(enc_i(12'd9, 5'd0, 3'd0, 5'd1, OPI), 64'd0, 1'b1);
        apply(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd0, OP), 64'd0, 1'b0);
        chk("rst_mid_alu", alu_result, 64'd0);
        chk("rst_mid_rs2", rs2_data, 64'd0);

        // Fill registers with full-width random data through loads
        for (int i = 1; i < 32; i++) begin
            model_step(19, 5'd0, 5'd0, 5'(i), 12'd0, 3'd3, {$urandom, $urandom}, 1'b0);
        end

        // Randomized instruction stream
        for (int n = 0; n < 800; n++) begin
            logic [4:0] r1, r2;
            r1 = 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom);
            model_step(int'($urandom_range(0, NK - 1)), r1, r2, 5'($urandom), 12'($urandom),
                       3'($urandom), {$urandom, $urandom}, $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
